// File: rtl/soc_system_input_debounce_if.sv
// soc_system_input_debounce_if: input-conditioning bus; master drives raw_in/edge_clear, slave returns debounced/rise/fall/edge_capture/irq
interface soc_system_input_debounce_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] raw_in, edge_clear, debounced, rise, fall, edge_capture;
  logic irq;
  modport master (output raw_in, edge_clear, input debounced, rise, fall, edge_capture, irq);
  modport slave (input raw_in, edge_clear, output debounced, rise, fall, edge_capture, irq);
endinterface

// File: rtl/soc_system_input_debounce.sv
// soc_system_input_debounce: per-bit synchronizer + stability counter + registered level with rise/fall pulses; ports clk, reset (sync active-high), bus (slave: raw_in/edge_clear in, debounced/rise/fall/edge_capture/irq out); SOC_SYSTEM_DEBOUNCE_EDGE_CAPTURE_EN adds sticky edge flags and irq
module soc_system_input_debounce #(
  parameter int WIDTH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH = 20,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic clk,
  input logic reset,
  soc_system_input_debounce_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync, deb_q, rise_q, fall_q;
  logic [CNT_WIDTH-1:0] cnt_q [WIDTH];
  assign sync = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RST_VAL;
    end else begin
      sync_q[0] <= bus.raw_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_q <= RST_VAL;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        rise_q[i] <= 1'b0;
        fall_q[i] <= 1'b0;
        if (sync[i] == deb_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == CNT_MAX) begin
          deb_q[i] <= sync[i];
          cnt_q[i] <= '0;
          rise_q[i] <= sync[i];
          fall_q[i] <= ~sync[i];
        end else cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end
  assign bus.debounced = deb_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
`ifdef SOC_SYSTEM_DEBOUNCE_EDGE_CAPTURE_EN
  logic [WIDTH-1:0] cap_q;
  logic irq_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cap_q <= (cap_q & ~bus.edge_clear) | rise_q | fall_q;
      irq_q <= |cap_q;
    end
  end
  assign bus.edge_capture = cap_q;
  assign bus.irq = irq_q;
`else
  logic unused_edge_clear;
  assign unused_edge_clear = |bus.edge_clear;
  assign bus.edge_capture = '0;
  assign bus.irq = 1'b0;
`endif
endmodule
